// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one line-granular physical memory port between an
// instruction-side and a data-side cache. One transaction in flight at a
// time, round-robin on simultaneous requests, registered downstream request,
// response steered combinationally to the granted cache only.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction-side cache
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  // data-side cache
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  // physical memory
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Round-robin pointer: 0 favours I, 1 favours D on a simultaneous request.
  logic prio;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic done;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, grant decision and response steering.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    case (state)
      IDLE: begin
        // pmem_resp is ignored here; only requests can leave IDLE.
        if (i_req && (!d_req || !prio)) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_resp     = 1'b1;
          i_rdata    = pmem_rdata;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_resp     = 1'b1;
          d_rdata    = pmem_rdata;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Downstream request registers and priority pointer: latch on grant, drop
  // strobes and hand priority to the other port on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio         <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      if (grant_i) begin
        pmem_address <= i_address;
        pmem_wdata   <= i_wdata;
        pmem_write   <= i_write;
        pmem_read    <= i_read & ~i_write;
      end else if (grant_d) begin
        pmem_address <= d_address;
        pmem_wdata   <= d_wdata;
        pmem_write   <= d_write;
        pmem_read    <= d_read & ~d_write;
      end
      if (done) begin
        pmem_read  <= 1'b0;
        pmem_write <= 1'b0;
        prio       <= (state == SERVE_I);
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter with hand-computed expectations.
module tb_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk;
  logic          rst_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] i_wdata, d_wdata;
  logic          i_resp, d_resp;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [LW-1:0] LINE_AA = {16{8'hAA}};
  localparam logic [LW-1:0] LINE_55 = {16{8'h55}};
  localparam logic [LW-1:0] LINE_77 = {16{8'h77}};
  localparam logic [LW-1:0] LINE_FF = {16{8'hFF}};

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_write = 1'b0; i_address = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Reset state
    check_eq("rst_pmem_read",  pmem_read,    0);
    check_eq("rst_pmem_write", pmem_write,   0);
    check_eq("rst_pmem_addr",  pmem_address, 0);
    check_eq("rst_pmem_wdata", pmem_wdata,   0);
    check_eq("rst_i_resp",     i_resp,       0);
    check_eq("rst_d_resp",     d_resp,       0);
    check_eq("rst_i_rdata",    i_rdata,      0);
    check_eq("rst_d_rdata",    d_rdata,      0);

    // --- I read alone at 0x1230, memory answers 3 cycles after grant
    i_read = 1'b1; i_address = 16'h1230;
    tick();
    check_eq("t1_pmem_read", pmem_read, 1);
    check_eq("t1_pmem_write", pmem_write, 0);
    check_eq("t1_pmem_addr", pmem_address, 16'h1230);
    check_eq("t1_i_resp_wait0", i_resp, 0);
    tick();
    check_eq("t1_i_resp_wait1", i_resp, 0);
    tick();
    check_eq("t1_pmem_read_hold", pmem_read, 1);
    pmem_resp = 1'b1; pmem_rdata = LINE_AA;
    #1;
    check_eq("t1_i_resp", i_resp, 1);
    check_eq("t1_i_rdata", i_rdata, LINE_AA);
    check_eq("t1_d_resp", d_resp, 0);
    check_eq("t1_d_rdata", d_rdata, 0);
    $display("txn I read addr 1230");
    tick();
    i_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    check_eq("t1_after_pmem_read", pmem_read, 0);
    check_eq("t1_after_i_resp", i_resp, 0);

    // --- I read and D write together after reset: I first, then D after one idle cycle
    do_reset();
    i_read = 1'b1; i_address = 16'h2220;
    d_write = 1'b1; d_address = 16'h4560; d_wdata = LINE_55;
    tick();
    check_eq("t2_grant_i_addr", pmem_address, 16'h2220);
    check_eq("t2_grant_i_read", pmem_read, 1);
    pmem_resp = 1'b1; pmem_rdata = LINE_AA;
    #1;
    check_eq("t2_i_resp", i_resp, 1);
    check_eq("t2_d_resp_idle", d_resp, 0);
    $display("txn I read addr 2220");
    tick();
    i_read = 1'b0; pmem_resp = 1'b0;
    check_eq("t2_idle_read", pmem_read, 0);
    check_eq("t2_idle_write", pmem_write, 0);
    tick();
    check_eq("t2_d_write", pmem_write, 1);
    check_eq("t2_d_read", pmem_read, 0);
    check_eq("t2_d_addr", pmem_address, 16'h4560);
    check_eq("t2_d_wdata", pmem_wdata, LINE_55);
    pmem_resp = 1'b1; pmem_rdata = LINE_77;
    #1;
    check_eq("t2_d_resp", d_resp, 1);
    check_eq("t2_d_rdata", d_rdata, LINE_77);
    check_eq("t2_i_resp_off", i_resp, 0);
    check_eq("t2_i_rdata_off", i_rdata, 0);
    $display("txn D write addr 4560");
    tick();
    d_write = 1'b0; pmem_resp = 1'b0;

    // --- Both request continuously: alternate I, D, I, D, I, D with idle gaps
    i_read = 1'b1; i_address = 16'h1000;
    d_read = 1'b1; d_address = 16'h2000;
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = (k % 2) == 1;
      tick();
      check_eq("t3_addr", pmem_address, exp_d ? 16'h2000 : 16'h1000);
      check_eq("t3_read", pmem_read, 1);
      pmem_resp = 1'b1; pmem_rdata = LINE_AA;
      #1;
      check_eq("t3_i_resp", i_resp, !exp_d);
      check_eq("t3_d_resp", d_resp, exp_d);
      $display("txn %0d %s read", k, exp_d ? "D" : "I");
      tick();
      pmem_resp = 1'b0;
      check_eq("t3_gap_read", pmem_read, 0);
    end
    i_read = 1'b0; d_read = 1'b0;

    // --- D read+write together behaves as write
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0010; d_wdata = LINE_77;
    tick();
    check_eq("t4_write", pmem_write, 1);
    check_eq("t4_read", pmem_read, 0);
    check_eq("t4_addr", pmem_address, 16'h0010);
    tick();
    check_eq("t4_d_resp_wait", d_resp, 0);
    pmem_resp = 1'b1;
    #1;
    check_eq("t4_d_resp", d_resp, 1);
    $display("txn D write addr 0010");
    tick();
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;

    // --- Spurious pmem_resp in IDLE
    tick();
    pmem_resp = 1'b1; pmem_rdata = LINE_FF;
    #1;
    check_eq("t5_i_resp", i_resp, 0);
    check_eq("t5_d_resp", d_resp, 0);
    check_eq("t5_i_rdata", i_rdata, 0);
    tick();
    pmem_resp = 1'b0;
    check_eq("t5_idle_read", pmem_read, 0);
    // A new request must be granted at once from IDLE
    i_read = 1'b1; i_address = 16'h3330;
    tick();
    check_eq("t5_grant_addr", pmem_address, 16'h3330);
    check_eq("t5_grant_read", pmem_read, 1);
    pmem_resp = 1'b1;
    #1;
    check_eq("t5_i_resp", i_resp, 1);
    $display("txn I read addr 3330");
    tick();
    i_read = 1'b0; pmem_resp = 1'b0;

    // --- Reset during SERVE_D write (priority currently favours D)
    d_write = 1'b1; d_address = 16'h5550; d_wdata = LINE_55;
    tick();
    check_eq("t6_write", pmem_write, 1);
    pmem_resp = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_write", pmem_write, 0);
    check_eq("t6_rst_addr", pmem_address, 0);
    check_eq("t6_rst_wdata", pmem_wdata, 0);
    check_eq("t6_rst_d_resp", d_resp, 0);
    check_eq("t6_rst_d_rdata", d_rdata, 0);
    pmem_resp = 1'b0; d_write = 1'b0;
    $display("txn D write addr 5550 aborted by reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i_read = 1'b1; i_address = 16'h6660;
    d_read = 1'b1; d_address = 16'h7770;
    tick();
    check_eq("t6_post_grant_addr", pmem_address, 16'h6660);
    pmem_resp = 1'b1;
    #1;
    check_eq("t6_post_i_resp", i_resp, 1);
    check_eq("t6_post_d_resp", d_resp, 0);
    $display("txn I read addr 6660");
    tick();
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port physical-memory arbiter that shares the single 128-bit line-granular physical memory interface between an instruction-side cache and a data-side cache. It sits between the two caches and physical memory. It serializes their line reads and writebacks, one transaction at a time, with round-robin priority on simultaneous requests. It registers the downstream request and routes the response back to the granted cache only.

## Interface
- ADDR_WIDTH, 16, width of all address ports
- LINE_WIDTH, 128, width of all line data ports
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read, i_write  in  1 each  I-side line read / writeback request; held until i_resp
- i_address  in  ADDR_WIDTH  I-side line address
- i_wdata  in  LINE_WIDTH  I-side writeback line
- i_resp  out  1  I-side completion pulse
- i_rdata  out  LINE_WIDTH  I-side read line
- d_read, d_write, d_address, d_wdata, d_resp, d_rdata: same as the I-side ports, for the D-side
- pmem_read, pmem_write  out  1 each  downstream request strobes, registered
- pmem_address  out  ADDR_WIDTH  registered downstream address
- pmem_wdata  out  LINE_WIDTH  registered downstream write line
- pmem_resp  in  1  downstream completion, one cycle
- pmem_rdata  in  LINE_WIDTH  downstream read line, valid with pmem_resp

## Operation
- Three states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- A port requests when its read or write is high.
- If a port asserts read and write together, the arbiter treats it as a write.
- Transitions out of IDLE:
  - Only I requests: go to SERVE_I.
  - Only D requests: go to SERVE_D.
  - Both request: go to the port named by the priority pointer prio.
  - Neither requests: stay in IDLE.
- Latching on grant, at the IDLE-exit edge:
  - pmem_address and pmem_wdata take the granted port's address and wdata.
  - pmem_read / pmem_write take the granted port's read / (write) strobes, with write forcing read low.
- These registers hold until the transaction ends. Requester inputs are not resampled during SERVE.
- In SERVE_x with pmem_resp=1:
  - x_resp=1 combinationally in the same cycle.
  - x_rdata=pmem_rdata combinationally in the same cycle.
  - Next state is IDLE. pmem_read and pmem_write clear at that edge.
  - prio is set to the other port.
- In SERVE_x with pmem_resp=0: stay in SERVE_x with outputs unchanged.
- prio resets to I. It changes only on transaction completion.
- x_resp is asserted only in SERVE_x with pmem_resp=1. The non-granted port's resp is always 0.
- x_rdata is 0 whenever x_resp=0.
- pmem_resp arriving in IDLE is ignored: no resp pulse and no state change.
- If the requester drops its request mid-SERVE, the downstream transaction still runs to completion and x_resp still pulses.
- Reset asserted mid-transaction:
  - State goes to IDLE immediately and prio goes to I.
  - All outputs go to 0 asynchronously.
  - The outstanding memory transaction is abandoned.
- Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0, i_rdata=0, d_rdata=0.

## Timing
- Grant latency:
  - A request seen high at edge N while in IDLE gives pmem_read/pmem_write high in the cycle after edge N.
  - Minimum latency is 1 cycle.
- Response latency is 0 cycles: x_resp coincides with pmem_resp.
- Turnaround:
  - After completion there is exactly one IDLE cycle before the next grant.
  - Back-to-back transactions are therefore separated by at least one cycle with pmem_read=pmem_write=0.
- The requester sees x_resp and deasserts its request by the following edge. The mandatory IDLE cycle guarantees a stale request is never regranted.
- Worst-case wait for a port with its request held: one full transaction of the other port plus the IDLE cycle.

## Test plan
- Reset, then I read at address 0x1230 alone; memory responds 3 cycles later with 0xAA..AA.
  - pmem_read=1 and pmem_address=0x1230 one cycle after the request.
  - i_resp=1 and i_rdata=0xAA..AA in the pmem_resp cycle.
  - d_resp stays 0.
- I read and D write (address 0x4560, wdata 0x55..55) raised in the same cycle after reset.
  - I is served first. pmem_write=1 with address 0x4560 is issued one IDLE cycle after i_resp.
- Both ports request continuously for 6 transactions.
  - Grants alternate I, D, I, D, I, D.
  - Every transaction is followed by one idle cycle.
- D asserts read and write together at address 0x0010.
  - pmem_write=1 and pmem_read=0 are issued.
  - d_resp pulses on pmem_resp.
- Spurious pmem_resp=1 in IDLE.
  - No resp pulse on either port and the state stays IDLE.
- rst_n pulsed low while in SERVE_D with pmem_write=1.
  - All outputs go to 0 immediately.
  - After release, a simultaneous request grants I first.
